// File: rtl/dii_worm_rr_arbiter_if.sv
// dii_worm_rr_arbiter_if: DII flit bundle between N requesters and one arbitrated output.
// Ports: in_valid/in_last/in_data per input, in_ready back to each input;
//        out_valid/out_last/out_data toward downstream, out_ready from downstream.
// master drives the requests and out_ready; slave is the arbiter side.
interface dii_worm_rr_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0][15:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic               out_last;
    logic [15:0]        out_data;
    logic               out_ready;
    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data
    );
    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data
    );
endinterface

// File: rtl/dii_worm_rr_arbiter.sv
// dii_worm_rr_arbiter: packet (worm) level round-robin arbiter sharing one DII output among N inputs.
// Ports: clk, rst (sync, active high); bus (slave modport: N request flits in, one flit out);
//        grant = owning/selected input, busy = worm lock held, worm_cnt = completed worms (wraps).
module dii_worm_rr_arbiter #(
    parameter int N     = 3,
    parameter int PRIO0 = 0,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    dii_worm_rr_arbiter_if.slave   bus,
    output logic [$clog2(N)-1:0]   grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       worm_cnt
);
    localparam int GW = $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WORM = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr, grant_q, rr_sel, sel, nxt, idx;
    logic          any_valid, live, fire;

    // Circular search from rr_ptr; walking backwards lets the closest valid input win.
    always_comb begin
        rr_sel = '0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_ptr) + k) % N);
            if (bus.in_valid[idx]) rr_sel = idx;
        end
    end

    // live: a head or the worm owner is connected to the output this cycle.
    always_comb begin
        any_valid     = |bus.in_valid;
        sel           = (state == WORM) ? grant_q : (PRIO0 != 0 && bus.in_valid[0]) ? '0 : rr_sel;
        nxt           = (sel == GW'(N - 1)) ? '0 : sel + 1'b1;
        live          = !rst && (state == WORM || any_valid);
        bus.out_valid = live && bus.in_valid[sel];
        bus.out_last  = bus.in_last[sel];
        bus.out_data  = bus.in_data[sel];
        bus.in_ready  = '0;
        bus.in_ready[sel] = live && bus.out_ready;
        fire          = bus.out_valid && bus.out_ready;
        grant         = rst ? '0 : live ? sel : grant_q;
        busy          = !rst && state == WORM;
    end

    // Any presented head that does not finish in the same cycle locks the grant,
    // including a single-flit head stalled by out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            worm_cnt <= '0;
        end else if (state == IDLE) begin
            if (any_valid) begin
                rr_ptr <= nxt;
                if (fire && bus.out_last) begin
                    worm_cnt <= worm_cnt + 1'b1;
                end else begin
                    state   <= WORM;
                    grant_q <= sel;
                end
            end
        end else if (fire && bus.out_last) begin
            state    <= IDLE;
            worm_cnt <= worm_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dii_worm_rr_arbiter.sv
// tb_dii_worm_rr_arbiter: scenario tasks for the worm arbiter; dut0 is round-robin, dut1 has input-0 priority.
module tb_dii_worm_rr_arbiter;
    logic        clk, rst, ordy;
    logic [1:0]  g0, g1;
    logic        bz0, bz1;
    logic [15:0] wc0, wc1;
    logic [2:0]  h0;
    logic [16:0] s0 [3][$];
    logic [16:0] s1 [3][$];
    logic [16:0] q0 [$];
    logic [16:0] q1 [$];
    int          checks, errors;

    dii_worm_rr_arbiter_if #(.N(3)) b0 ();
    dii_worm_rr_arbiter_if #(.N(3)) b1 ();

    dii_worm_rr_arbiter #(.N(3), .PRIO0(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .grant(g0), .busy(bz0), .worm_cnt(wc0)
    );
    dii_worm_rr_arbiter #(.N(3), .PRIO0(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .grant(g1), .busy(bz1), .worm_cnt(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            b0.in_valid[i] = s0[i].size() > 0 && !h0[i];
            b0.in_last[i]  = s0[i].size() > 0 ? s0[i][0][16] : 1'b0;
            b0.in_data[i]  = s0[i].size() > 0 ? s0[i][0][15:0] : 16'h0;
            b1.in_valid[i] = s1[i].size() > 0;
            b1.in_last[i]  = s1[i].size() > 0 ? s1[i][0][16] : 1'b0;
            b1.in_data[i]  = s1[i].size() > 0 ? s1[i][0][15:0] : 16'h0;
        end
        b0.out_ready = ordy;
        b1.out_ready = 1'b1;
    endtask

    // One clock: scoreboard the transferring flits at negedge, consume accepted source flits,
    // then re-drive and let the combinational outputs settle.
    task automatic tick();
        logic [2:0]  a0, a1;
        logic [16:0] e;
        @(negedge clk);
        if (!rst && b0.out_valid && b0.out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_extra got %h want none", {b0.out_last, b0.out_data});
            end else begin
                e = q0.pop_front();
                if ({b0.out_last, b0.out_data} !== e) begin
                    errors++;
                    $display("FAIL sb0_flit got %h want %h", {b0.out_last, b0.out_data}, e);
                end
            end
        end
        if (!rst && b1.out_valid && b1.out_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_extra got %h want none", {b1.out_last, b1.out_data});
            end else begin
                e = q1.pop_front();
                if ({b1.out_last, b1.out_data} !== e) begin
                    errors++;
                    $display("FAIL sb1_flit got %h want %h", {b1.out_last, b1.out_data}, e);
                end
            end
        end
        a0 = b0.in_valid & b0.in_ready;
        a1 = b1.in_valid & b1.in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (a0[i]) void'(s0[i].pop_front());
            if (a1[i]) void'(s1[i].pop_front());
        end
        drive();
        #1;
    endtask

    function automatic int pending();
        int n;
        n = q0.size() + q1.size();
        for (int i = 0; i < 3; i++) n += s0[i].size() + s1[i].size();
        return n;
    endfunction

    task automatic drain();
        for (int n = 0; n < 40 && pending() != 0; n++) tick();
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", pending());
        end
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        ordy = 1'b1;
        h0 = '0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            s0[i].delete();
            s1[i].delete();
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        drive();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            s0[i].push_back({1'b1, 16'h0B00 + 16'(i)});
            q0.push_back({1'b1, 16'h0B00 + 16'(i)});
        end
        drive();
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks += 4;
            if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b0.out_valid); end
            if (b0.in_ready !== 3'b000) begin errors++; $display("FAIL rst_in_ready got %b want 000", b0.in_ready); end
            if (bz0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bz0); end
            if (wc0 !== 16'd0) begin errors++; $display("FAIL rst_worm_cnt got %0d want 0", wc0); end
        end
        rst = 1'b0;
        drive();
        #1;
        checks += 2;
        if (g0 !== 2'd0) begin errors++; $display("FAIL rst_first_grant got %0d want 0", g0); end
        if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %b want 1", b0.out_valid); end
        drain();
    endtask

    task automatic test_round_robin();
        apply_rst();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) begin
                s0[i].push_back({1'b1, 16'h0A00 + 16'(i)});
                q0.push_back({1'b1, 16'h0A00 + 16'(i)});
            end
        drive();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g0 !== 2'(k % 3)) begin errors++; $display("FAIL rr_grant got %0d want %0d", g0, k % 3); end
            tick();
        end
        checks++;
        if (wc0 !== 16'd4) begin errors++; $display("FAIL rr_worm_cnt got %0d want 4", wc0); end
        drain();
    endtask

    task automatic test_worm_lock();
        apply_rst();
        for (int k = 1; k <= 4; k++) begin
            s0[1].push_back({k == 4, 16'h0010 + 16'(k)});
            q0.push_back({k == 4, 16'h0010 + 16'(k)});
        end
        q0.push_back({1'b1, 16'h0500});
        drive();
        #1;
        checks++;
        if (g0 !== 2'd1) begin errors++; $display("FAIL lock_head_grant got %0d want 1", g0); end
        tick();
        s0[0].push_back({1'b1, 16'h0500});
        drive();
        #1;
        for (int k = 2; k <= 4; k++) begin
            checks += 3;
            if (bz0 !== 1'b1) begin errors++; $display("FAIL lock_busy got %b want 1", bz0); end
            if (b0.in_ready[0] !== 1'b0) begin errors++; $display("FAIL lock_in_ready0 got %b want 0", b0.in_ready[0]); end
            if (g0 !== 2'd1) begin errors++; $display("FAIL lock_grant got %0d want 1", g0); end
            tick();
        end
        checks += 2;
        if (g0 !== 2'd0) begin errors++; $display("FAIL lock_next_grant got %0d want 0", g0); end
        if (bz0 !== 1'b0) begin errors++; $display("FAIL lock_release_busy got %b want 0", bz0); end
        drain();
    endtask

    task automatic test_backpressure();
        apply_rst();
        ordy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            s0[2].push_back({k == 3, 16'h0020 + 16'(k)});
            q0.push_back({k == 3, 16'h0020 + 16'(k)});
        end
        q0.push_back({1'b1, 16'h0600});
        drive();
        #1;
        for (int c = 0; c < 3; c++) begin
            checks += 3;
            if (g0 !== 2'd2) begin errors++; $display("FAIL bp_stall_grant got %0d want 2", g0); end
            if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b want 1", b0.out_valid); end
            if (b0.in_ready !== 3'b000) begin errors++; $display("FAIL bp_stall_ready got %b want 000", b0.in_ready); end
            tick();
            if (c == 0) begin
                s0[0].push_back({1'b1, 16'h0600});
                drive();
                #1;
            end
        end
        ordy = 1'b1;
        drive();
        #1;
        checks += 2;
        if (g0 !== 2'd2) begin errors++; $display("FAIL bp_resume_grant got %0d want 2", g0); end
        if (b0.in_ready !== 3'b100) begin errors++; $display("FAIL bp_resume_ready got %b want 100", b0.in_ready); end
        h0[2] = 1'b1;
        tick();
        checks += 4;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble_valid got %b want 0", b0.out_valid); end
        if (g0 !== 2'd2) begin errors++; $display("FAIL bp_bubble_grant got %0d want 2", g0); end
        if (bz0 !== 1'b1) begin errors++; $display("FAIL bp_bubble_busy got %b want 1", bz0); end
        if (b0.in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_bubble_ready0 got %b want 0", b0.in_ready[0]); end
        h0[2] = 1'b0;
        drain();
        checks++;
        if (wc0 !== 16'd2) begin errors++; $display("FAIL bp_worm_cnt got %0d want 2", wc0); end
    endtask

    task automatic test_prio0();
        apply_rst();
        for (int k = 0; k < 3; k++) begin
            s1[0].push_back({1'b1, 16'h0C00 + 16'(k)});
            q1.push_back({1'b1, 16'h0C00 + 16'(k)});
        end
        s1[1].push_back({1'b1, 16'h0D00});
        q1.push_back({1'b1, 16'h0D00});
        drive();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g1 !== (k < 3 ? 2'd0 : 2'd1)) begin errors++; $display("FAIL prio_grant got %0d want %0d", g1, k < 3 ? 0 : 1); end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_worm();
        apply_rst();
        s0[0].push_back({1'b1, 16'h0300});
        q0.push_back({1'b1, 16'h0300});
        for (int k = 1; k <= 4; k++) s0[1].push_back({k == 4, 16'h0030 + 16'(k)});
        q0.push_back({1'b0, 16'h0031});
        q0.push_back({1'b0, 16'h0032});
        drive();
        #1;
        checks++;
        if (g0 !== 2'd0) begin errors++; $display("FAIL mid_first_grant got %0d want 0", g0); end
        tick();
        checks++;
        if (g0 !== 2'd1) begin errors++; $display("FAIL mid_worm_grant got %0d want 1", g0); end
        tick();
        checks += 2;
        if (bz0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bz0); end
        if (wc0 !== 16'd1) begin errors++; $display("FAIL mid_worm_cnt got %0d want 1", wc0); end
        tick();
        rst = 1'b1;
        s0[1].delete();
        s0[2].push_back({1'b1, 16'h0700});
        q0.push_back({1'b1, 16'h0700});
        drive();
        #1;
        checks += 2;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", b0.out_valid); end
        if (b0.in_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_ready got %b want 000", b0.in_ready); end
        tick();
        rst = 1'b0;
        drive();
        #1;
        checks += 4;
        if (bz0 !== 1'b0) begin errors++; $display("FAIL mid_after_busy got %b want 0", bz0); end
        if (wc0 !== 16'd0) begin errors++; $display("FAIL mid_after_worm_cnt got %0d want 0", wc0); end
        if (g0 !== 2'd2) begin errors++; $display("FAIL mid_after_grant got %0d want 2", g0); end
        if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid got %b want 1", b0.out_valid); end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ordy = 1'b1;
        h0 = '0;
        drive();
        test_reset();
        test_round_robin();
        test_worm_lock();
        test_backpressure();
        test_prio0();
        test_reset_mid_worm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
